// File: rtl/alu_datapath_core.sv
// Multi-cycle register-bank datapath with a 6502-style ALU.
// One micro-op per command handshake; result and flags on a result handshake.
module alu_datapath_core #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_a,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_b,
  input  logic                  cmd_use_imm,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_d,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [3:0]            res_flags,
  input  logic [SEL_WIDTH-1:0]  dbg_sel,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int W = DATA_WIDTH;
  localparam logic [SEL_WIDTH:0] NREG = (SEL_WIDTH+1)'(NUM_REGS);

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_ASL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;
  localparam logic [3:0] OP_PAS = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;
  localparam logic [3:0] OP_BIT = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0]         regs [NUM_REGS];
  logic [3:0]           status;
  logic [3:0]           op_q;
  logic [SEL_WIDTH-1:0] sa_q;
  logic [SEL_WIDTH-1:0] sb_q;
  logic [SEL_WIDTH-1:0] sd_q;
  logic                 imm_q_sel;
  logic [W-1:0]         imm_q;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;
  logic [W-1:0]         res_q;
  logic [3:0]           flag_q;

  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b;
  logic         wr_en;

  // Out-of-range selects read as zero and never write.
  assign rd_a = ({1'b0, sa_q} < NREG) ? regs[sa_q] : '0;
  assign rd_b = ({1'b0, sb_q} < NREG) ? regs[sb_q] : '0;
  assign dbg_data = ({1'b0, dbg_sel} < NREG) ? regs[dbg_sel] : '0;
  assign wr_en = (op_q < OP_CMP) && ({1'b0, sd_q} < NREG);

  logic [W-1:0] bb;
  logic         cin;
  logic [W:0]   sum;
  logic [W-1:0] alu_r;
  logic [3:0]   alu_f;
  logic         upd;
  logic         fn;
  logic         fv;
  logic         fz;
  logic         fc;
  logic         add_ov;

  always_comb begin
    bb     = (op_q == OP_SBC || op_q == OP_CMP) ? ~b_q : b_q;
    cin    = (op_q == OP_CMP) ? 1'b1 : status[0];
    sum    = {1'b0, a_q} + {1'b0, bb} + (W+1)'(cin);
    add_ov = (a_q[W-1] == bb[W-1]) && (sum[W-1] != a_q[W-1]);
    alu_r  = '0;
    upd    = 1'b1;
    fn     = status[3];
    fv     = status[2];
    fz     = status[1];
    fc     = status[0];
    unique case (op_q)
      OP_ADC, OP_SBC: begin
        alu_r = sum[W-1:0];
        fc    = sum[W];
        fv    = add_ov;
      end
      OP_AND: alu_r = a_q & b_q;
      OP_ORA: alu_r = a_q | b_q;
      OP_EOR: alu_r = a_q ^ b_q;
      OP_ASL: begin
        alu_r = {a_q[W-2:0], 1'b0};
        fc    = a_q[W-1];
      end
      OP_LSR: begin
        alu_r = {1'b0, a_q[W-1:1]};
        fc    = a_q[0];
      end
      OP_ROL: begin
        alu_r = {a_q[W-2:0], status[0]};
        fc    = a_q[W-1];
      end
      OP_ROR: begin
        alu_r = {status[0], a_q[W-1:1]};
        fc    = a_q[0];
      end
      OP_INC: alu_r = a_q + 1'b1;
      OP_DEC: alu_r = a_q - 1'b1;
      OP_PAS: alu_r = b_q;
      OP_CMP: begin
        alu_r = sum[W-1:0];
        fc    = sum[W];
      end
      OP_BIT: begin
        alu_r = a_q & b_q;
        fv    = b_q[W-2];
      end
      default: upd = 1'b0;
    endcase
    if (upd) begin
      fn = alu_r[W-1];
      fz = (alu_r == '0);
      if (op_q == OP_BIT) fn = b_q[W-1];
    end
    alu_f = {fn, fv, fz, fc};
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_nx = S_FETCH;
      S_FETCH: state_nx = S_EXEC;
      S_EXEC:  state_nx = S_WB;
      S_WB:    state_nx = S_RESP;
      S_RESP:  if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign res_valid = (state == S_RESP);
  assign res_data  = res_q;
  assign res_flags = status;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      status    <= '0;
      op_q      <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      sd_q      <= '0;
      imm_q_sel <= 1'b0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      flag_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            sa_q      <= cmd_sel_a;
            sb_q      <= cmd_sel_b;
            sd_q      <= cmd_sel_d;
            imm_q_sel <= cmd_use_imm;
            imm_q     <= cmd_imm;
          end
        end
        S_FETCH: begin
          a_q <= rd_a;
          b_q <= imm_q_sel ? imm_q : rd_b;
        end
        S_EXEC: begin
          res_q  <= alu_r;
          flag_q <= alu_f;
        end
        S_WB: begin
          status <= flag_q;
          if (wr_en) regs[sd_q] <= res_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_datapath_core.md
Name: alu_datapath_core

Overview:
- Parametrised successor to the single-ALU CPU datapath: a register bank of NUM_REGS general registers plus a status register, a dual operand-select path and a 6502-style ALU.
- Sequenced by a small multi-cycle FSM on a single clock, replacing the phi1/phi2 split.
- Accepts one micro-op per command handshake, executes it and returns the result with flags over a result handshake.
- Sits between the instruction decoder (command side) and the bus/retire logic (result side).

Parameters:
DATA_WIDTH, 8, width of every register, operand and result
NUM_REGS, 8, number of general registers (minimum 2)
SEL_WIDTH, 3, register-select width; ceil(log2(NUM_REGS))

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  core can accept a command
cmd_op  in  4  operation code (see Behaviour)
cmd_sel_a  in  SEL_WIDTH  operand A register
cmd_sel_b  in  SEL_WIDTH  operand B register
cmd_use_imm  in  1  1: operand B = cmd_imm
cmd_imm  in  DATA_WIDTH  immediate operand
cmd_sel_d  in  SEL_WIDTH  destination register
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_data  out  DATA_WIDTH  ALU result
res_flags  out  4  {N,V,Z,C} after the op
dbg_sel  in  SEL_WIDTH  debug read select
dbg_data  out  DATA_WIDTH  combinational read of register dbg_sel

Behaviour:
- Reset (sync, active-high, sampled on clk rise):
  - all registers and status = 0; FSM = IDLE
  - cmd_ready = 1, res_valid = 0, res_data = 0, res_flags = 0
  - reset dominates any handshake in the same cycle
  - reset during any state aborts the op with no register write
- FSM: IDLE -> FETCH -> EXEC -> WB -> RESP -> IDLE.
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, latch all cmd_* fields and go to FETCH.
  - FETCH: read A and B (or the immediate) into operand latches.
  - EXEC: compute result and flags into the result latch.
  - WB: write result to sel_d unless op is CMP or BIT; update status.
  - RESP: res_valid = 1; hold res_data and res_flags stable until res_ready; on res_valid & res_ready go to IDLE.
- cmd_ready = 0 in every state except IDLE.
- Timing: res_valid rises exactly 3 cycles after the accepting edge. Minimum issue interval is 5 cycles when res_ready is held at 1.
- Operand reads in FETCH see the prior op's writeback, so there is no hazard.
- A select value >= NUM_REGS reads 0 and suppresses the write; status is still updated.
- Ops (cmd_op), all arithmetic modulo 2^DATA_WIDTH:
  - 0 ADC: A+B+C
  - 1 SBC: A+~B+C
  - 2 AND
  - 3 ORA
  - 4 EOR
  - 5 ASL A
  - 6 LSR A
  - 7 ROL A
  - 8 ROR A
  - 9 INC A
  - 10 DEC A
  - 11 PASS B
  - 12 CMP: A-B, no write
  - 13 BIT: A&B, no write
  - 14-15 NOP: result 0, no write, flags unchanged
- C flag:
  - ADC: carry out of MSB
  - SBC and CMP: 1 when no borrow (A>=B unsigned for CMP)
  - ASL and ROL: old A MSB
  - LSR and ROR: old A LSB
  - all other ops: unchanged
- V flag:
  - ADC and SBC: signed overflow
  - BIT: B[DATA_WIDTH-2]
  - all other ops: unchanged
- N flag = result MSB; for BIT, N = B MSB.
- Z flag = (result == 0); for BIT, Z = ((A&B) == 0).
- res_flags reflects the status register after the op.

Test Plan:
- Reset with cmd_valid = 1 -> no accept; res_valid = 0 and cmd_ready = 1 on the cycle after reset deasserts; dbg_data = 0 for all registers.
- PASS imm 0x7F to R1, then ADC R1 + imm 0x01 (C = 0) into R2 -> res_data = 0x80, flags N=1 V=1 Z=0 C=0; dbg R2 = 0x80; res_valid rises 3 cycles after each accept.
- ADC 0xFF + 0x01 (C = 0) -> res_data = 0x00, Z=1, C=1. Follow with ROL of a register holding 0x80 (C = 1) -> 0x01, C=1.
- CMP R1 = 0x10 against imm 0x20 -> N=1 C=0 Z=0, R-file unchanged. CMP 0x20 vs 0x20 -> Z=1 C=1.
- Hold res_ready = 0 for 4 cycles -> res_valid, res_data and res_flags stable and cmd_ready = 0 throughout; release -> IDLE next cycle; a new command is accepted.
- Assert reset while in EXEC for a write to R3 -> R3 stays 0, res_valid never asserts. Repeat the full suite with DATA_WIDTH = 16, NUM_REGS = 4: ADC 0xFFFF + 1 -> 0x0000 with C=1.
